// File: rtl/trace_pkg.sv
// Entry type shared by the trace capture FIFO and its storage.
// TRACE_BUFFER_TSTAMP_EN adds a 32-bit cycle stamp field to every entry.
package trace_pkg;

  localparam int DROP_CNT_W = 16;

  typedef struct packed {
`ifdef TRACE_BUFFER_TSTAMP_EN
    logic [31:0] tstamp;
`endif
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] data;
  } trace_entry_t;

endpackage

// File: rtl/trace_buffer_mem.sv
// Entry storage for the trace FIFO: one synchronous write port, one asynchronous read port.
// Contents are never reset; occupancy tracking in the parent decides what is valid.
module trace_buffer_mem
  import trace_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  trace_entry_t  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output trace_entry_t  rdata_o
);

  trace_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/trace_buffer.sv
// Capture FIFO behind the processor trace port: drops on overflow, flags and counts drops.
// Define TRACE_BUFFER_TSTAMP_EN to stamp each entry with a free-running cycle count.
module trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         trace_val,
  input  logic [31:0]                  trace_addr,
  input  logic [31:0]                  trace_inst,
  input  logic [31:0]                  trace_data,
  output logic                         deq_val,
  input  logic                         deq_rdy,
  output logic [31:0]                  deq_addr,
  output logic [31:0]                  deq_inst,
  output logic [31:0]                  deq_data,
`ifdef TRACE_BUFFER_TSTAMP_EN
  output logic [31:0]                  deq_tstamp,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic [DROP_CNT_W-1:0]        drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0]         wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic                  full, deq_fire, enq, mem_we;
  trace_entry_t          wr_entry, rd_entry;

  assign full     = (count_q == FULL_CNT);
  assign deq_val  = (count_q != '0);
  assign deq_fire = deq_val && deq_rdy;
  // A full buffer still accepts when the head retires in the same cycle.
  assign enq      = trace_val && (!full || deq_fire);
  assign mem_we   = enq && !clr;

  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clr) begin
      wp_d       = '0;
      rp_d       = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else begin
      if (enq)      wp_d = wp_q + AW'(1);
      if (deq_fire) rp_d = rp_q + AW'(1);
      case ({enq, deq_fire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (trace_val && !enq) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

`ifdef TRACE_BUFFER_TSTAMP_EN
  logic [31:0] cyc_q, cyc_d;

  // Runs through clr so stamps stay comparable across clears.
  assign cyc_d = cyc_q + 32'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cyc_q <= '0;
    else      cyc_q <= cyc_d;
  end
`endif

  always_comb begin
    wr_entry.addr   = trace_addr;
    wr_entry.inst   = trace_inst;
    wr_entry.data   = trace_data;
`ifdef TRACE_BUFFER_TSTAMP_EN
    wr_entry.tstamp = cyc_q;
`endif
  end

  trace_buffer_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wp_q),
    .wdata_i (wr_entry),
    .raddr_i (rp_q),
    .rdata_o (rd_entry)
  );

  assign deq_addr = rd_entry.addr;
  assign deq_inst = rd_entry.inst;
  assign deq_data = rd_entry.data;
`ifdef TRACE_BUFFER_TSTAMP_EN
  assign deq_tstamp = rd_entry.tstamp;
`endif

  assign count    = count_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_trace_buffer.sv
// Self-checking bench for trace_buffer: queue-based reference model plus directed literal checks.
module tb_trace_buffer;

  localparam int DEPTH = 8;
  localparam int CW = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr = 1'b0;
  logic          trace_val = 1'b0;
  logic [31:0]   trace_addr = '0, trace_inst = '0, trace_data = '0;
  logic          deq_val;
  logic          deq_rdy = 1'b0;
  logic [31:0]   deq_addr, deq_inst, deq_data;
`ifdef TRACE_BUFFER_TSTAMP_EN
  logic [31:0]   deq_tstamp;
`endif
  logic [CW-1:0] count;
  logic          overflow;
  logic [15:0]   drop_cnt;

  trace_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .trace_val  (trace_val),
    .trace_addr (trace_addr),
    .trace_inst (trace_inst),
    .trace_data (trace_data),
    .deq_val    (deq_val),
    .deq_rdy    (deq_rdy),
    .deq_addr   (deq_addr),
    .deq_inst   (deq_inst),
    .deq_data   (deq_data),
`ifdef TRACE_BUFFER_TSTAMP_EN
    .deq_tstamp (deq_tstamp),
`endif
    .count      (count),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] data;
    logic [31:0] ts;
  } ent_t;

  ent_t        mq[$];
  bit          m_ovf;
  int          m_drop;
  logic [31:0] m_cyc;
  logic [31:0] deq_log[$];
  int          n_vec = 0;
  int          n_err = 0;

  logic [31:0] jr_addr[3] = '{32'h0, 32'h4, 32'h10};
  logic [31:0] jr_inst[3] = '{32'h01000093, 32'h00008067, 32'h00000013};
  logic [31:0] jr_data[3] = '{32'h10, 32'h0, 32'h0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: queue of accepted entries; drop when already DEPTH deep after any retire.
  task automatic model_step();
    ent_t e;
    if (!rst) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_drop = 0;
      m_cyc  = '0;
    end else begin
      if (clr) begin
        mq.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
      end else begin
        if (mq.size() != 0 && deq_rdy) void'(mq.pop_front());
        if (trace_val) begin
          if (mq.size() < DEPTH) begin
            e.addr = trace_addr; e.inst = trace_inst; e.data = trace_data; e.ts = m_cyc;
            mq.push_back(e);
          end else begin
            m_ovf = 1'b1;
            if (m_drop < 65535) m_drop++;
          end
        end
      end
      m_cyc = m_cyc + 32'd1;
    end
  endtask

  task automatic compare();
    chk("deq_val", 32'(deq_val), 32'(mq.size() != 0));
    chk("count", 32'(count), mq.size());
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_cnt", 32'(drop_cnt), m_drop);
    if (mq.size() != 0) begin
      chk("deq_addr", deq_addr, mq[0].addr);
      chk("deq_inst", deq_inst, mq[0].inst);
      chk("deq_data", deq_data, mq[0].data);
`ifdef TRACE_BUFFER_TSTAMP_EN
      chk("deq_tstamp", deq_tstamp, mq[0].ts);
`endif
    end
  endtask

  task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] i,
                     input logic [31:0] d, input logic rdy, input logic c);
    trace_val = v; trace_addr = a; trace_inst = i; trace_data = d;
    deq_rdy = rdy; clr = c;
    if (rst && deq_val && rdy && !c) deq_log.push_back(deq_addr);
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b0, '0, '0, '0, rdy, 1'b0);
  endtask

  initial begin
    // Reset and single capture
    repeat (3) idle(1'b0);
    chk("rst_deq_val", 32'(deq_val), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    rst = 1'b1;
    idle(1'b0);
    chk("post_rst_count", 32'(count), 32'd0);
    cyc(1'b1, 32'h0, 32'h01000093, 32'h10, 1'b0, 1'b0);
    chk("cap_deq_val", 32'(deq_val), 32'd1);
    chk("cap_deq_addr", deq_addr, 32'h0);
    chk("cap_deq_data", deq_data, 32'h10);
    chk("cap_count", 32'(count), 32'd1);
    idle(1'b1);

    // Order through wrap-around
    deq_log.delete();
    for (int k = 0; k < 40; k++) begin
      if (k % 2 == 0) cyc(1'b1, jr_addr[(k/2)%3], jr_inst[(k/2)%3], jr_data[(k/2)%3], 1'b0, 1'b0);
      else            idle(1'b1);
    end
    idle(1'b1);
    chk("jr_n_retired", deq_log.size(), 32'd20);
    for (int j = 0; j < deq_log.size(); j++) chk("jr_order", deq_log[j], jr_addr[j%3]);

    // Overflow
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b1);
    for (int n = 0; n < 11; n++) cyc(1'b1, 32'h100 + 32'(4*n), 32'h13, 32'(n), 1'b0, 1'b0);
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_drop_cnt", 32'(drop_cnt), 32'd3);
    chk("ovf_head", deq_addr, 32'h100);

    // Full with simultaneous enqueue and dequeue
    cyc(1'b1, 32'h200, 32'h13, 32'hAA, 1'b1, 1'b0);
    chk("full_sim_count", 32'(count), 32'd8);
    chk("full_sim_drop", 32'(drop_cnt), 32'd3);
    chk("full_sim_head", deq_addr, 32'h104);
    repeat (7) idle(1'b1);
    chk("full_sim_last", deq_addr, 32'h200);
    chk("full_sim_last_cnt", 32'(count), 32'd1);

    // Clear priority
    for (int n = 0; n < 4; n++) cyc(1'b1, 32'h300 + 32'(4*n), 32'h13, 32'h0, 1'b0, 1'b0);
    chk("clr_pre_count", 32'(count), 32'd5);
    chk("clr_pre_ovf", 32'(overflow), 32'd1);
    cyc(1'b1, 32'h400, 32'h13, 32'h0, 1'b0, 1'b1);
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_drop", 32'(drop_cnt), 32'd0);
    chk("clr_deq_val", 32'(deq_val), 32'd0);

    // Asynchronous reset mid-stream
    for (int n = 0; n < 3; n++) cyc(1'b1, 32'h500 + 32'(4*n), 32'h13, 32'h0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    #1;
    chk("async_rst_val", 32'(deq_val), 32'd0);
    chk("async_rst_count", 32'(count), 32'd0);
    idle(1'b0);
    rst = 1'b1;

    // Randomized traffic: a filling phase then a draining phase
    for (int k = 0; k < 3000; k++) begin
      automatic logic v   = ($urandom_range(0, 9) < 7);
      automatic logic rdy = (k < 1500) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
      automatic logic c   = ($urandom_range(0, 199) == 0);
      cyc(v, $urandom, $urandom, $urandom, rdy, c);
    end

`ifdef TRACE_BUFFER_TSTAMP_EN
    // Timestamps relative to reset release
    #1 rst = 1'b0;
    idle(1'b0);
    rst = 1'b1;
    repeat (3) idle(1'b0);
    cyc(1'b1, 32'h600, 32'h13, 32'h0, 1'b0, 1'b0);
    repeat (3) idle(1'b0);
    cyc(1'b1, 32'h604, 32'h13, 32'h0, 1'b0, 1'b0);
    chk("tstamp_first", deq_tstamp, 32'd3);
    idle(1'b1);
    chk("tstamp_second", deq_tstamp, 32'd7);
    idle(1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/trace_buffer.md
# trace_buffer

Capture FIFO that sits directly downstream of the processor's trace port (`trace_val`/`trace_addr`/`trace_inst`/`trace_data`). Every retired instruction the processor reports is written into a circular buffer. A test bench or debug host drains the buffer at its own pace through a val/rdy dequeue interface. The processor trace port has no backpressure, so the block drops entries on overflow, flags the loss, and counts the dropped entries.

## Interface
- `DEPTH`, default 8: number of entries; power of two, at least 2.
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `clr`, in, 1: synchronous clear; empties the buffer, clears `overflow`, and zeroes `drop_cnt`.
- `trace_val`, in, 1: processor retired an instruction this cycle.
- `trace_addr`, in, 32: PC of the retired instruction.
- `trace_inst`, in, 32: instruction word.
- `trace_data`, in, 32: writeback data; X values are stored unmodified.
- `deq_val`, out, 1: the head entry is valid.
- `deq_rdy`, in, 1: the consumer accepts the head entry.
- `deq_addr`, out, 32: head entry PC.
- `deq_inst`, out, 32: head entry instruction word.
- `deq_data`, out, 32: head entry writeback data.
- `deq_tstamp`, out, 32: head entry cycle stamp; present only with `TRACE_BUFFER_TSTAMP_EN`.
- `count`, out, $clog2(DEPTH+1): number of occupied entries.
- `overflow`, out, 1: sticky flag; at least one entry was dropped since the last reset or clear.
- `drop_cnt`, out, 16: number of dropped entries; saturates at 0xFFFF.

## Operation
**Pointers and state**
- Write pointer `wp` and read pointer `rp` are each $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- Occupancy is held in `count`, so full and empty are unambiguous.
- Empty means `count==0`. Full means `count==DEPTH`.

**Enqueue and dequeue**
- Enqueue condition: `trace_val && (count<DEPTH || deq_fire)`.
- `deq_fire` = `deq_val && deq_rdy`.
- `deq_val` = `count!=0`. There is no bypass: an entry is never visible on the cycle it is written.
- `deq_*` outputs are driven from the entry at `rp`. They are held stable while `deq_val && !deq_rdy`.

**Boundary conditions**
- Full, and `trace_val` without `deq_fire`:
  - the entry is dropped;
  - `overflow` is set to 1;
  - `drop_cnt` increments, saturating at 0xFFFF;
  - buffer contents, `wp`, `rp`, and `count` are unchanged.
- Full, and `trace_val` with `deq_fire`: the head entry retires and the new entry is written; `count` stays at DEPTH.
- Empty, and `deq_rdy` asserted: no effect.
- Simultaneous enqueue and dequeue when not full: both pointers advance and `count` is unchanged.

**Clear**
- `clr` has priority over every other event in its cycle.
- After the clock edge: `wp=rp=0`, `count=0`, `overflow=0`, `drop_cnt=0`.
- A `trace_val` that arrives in the same cycle as `clr` is discarded without being counted as a drop.
- Entry storage contents are not cleared.

**Reset**
- Asserting `rst` low forces `wp`, `rp`, `count`, `overflow`, and `drop_cnt` to 0 immediately, without waiting for a clock edge.
- As a result `deq_val=0` while in reset. `deq_addr`, `deq_inst`, `deq_data`, and `deq_tstamp` are don't-care while `deq_val=0`.
- Reset asserted mid-stream loses all buffered entries. This is acceptable.

## Timing
- Capture-to-visible latency is 1 cycle: a `trace_val` sampled at edge N gives `deq_val=1` after edge N, with the entry at the head if the buffer was empty.
- A dequeue takes effect at the edge where `deq_fire` is true. The next entry appears on `deq_*` after that edge.
- Sustained throughput is 1 entry per cycle in and 1 entry per cycle out.
- `count`, `overflow`, and `drop_cnt` are registered outputs and reflect the state after the most recent edge.
- There are no combinational paths from `trace_*` to `deq_*`. `deq_rdy` affects only next-state logic.

## Configuration
- Macro: `TRACE_BUFFER_TSTAMP_EN`.
- Defined:
  - a 32-bit free-running cycle counter is added; it resets to 0, increments every cycle including while `clr` is high, and wraps from 0xFFFFFFFF to 0;
  - each enqueued entry stores the counter value from its enqueue cycle;
  - the stored value is presented on `deq_tstamp`.
- Undefined: the cycle counter and the `deq_tstamp` port are both absent, and entries are 96 bits wide.

## Structure
- Package `trace_pkg`:
  - `trace_entry_t` packed struct containing `addr`, `inst`, `data`, and `tstamp`; the `tstamp` field exists only under `TRACE_BUFFER_TSTAMP_EN`;
  - `DROP_CNT_W=16` constant.
- Sub-module `trace_buffer_mem`: a DEPTH-entry register array of `trace_entry_t` with one synchronous write port and one asynchronous read port.
- Pointer logic, count logic, and overflow logic stay in `trace_buffer`.

## Test plan
- **Reset and single capture:** hold `rst` low, then release; check `deq_val=0` and `count=0`. Pulse `trace_val` once with addr 0x0, inst addi x1,x0,0x010 (0x01000093), data 0x10. Next cycle: `deq_val=1`, `deq_addr=0x0`, `deq_data=0x10`, `count=1`.
- **Order through wrap-around:** run the jr sequence (addi at 0x000, jr x1 at 0x004, then the instruction at 0x010) for 20 retirements with `deq_rdy=1` every other cycle. Check the dequeued addresses match the retire order exactly across pointer wrap.
- **Overflow:** with `deq_rdy=0`, send 11 entries into `DEPTH=8`. Check `count=8`, `overflow=1`, `drop_cnt=3`, and that the head is still the first entry.
- **Full with simultaneous enqueue and dequeue:** fill the buffer to full, then assert `trace_val` and `deq_rdy` in the same cycle. Check `count` stays 8, `drop_cnt` is unchanged, and the new entry appears last.
- **Clear priority:** with `count=5` and `overflow=1`, assert `clr` together with `trace_val`. Next cycle: `count=0`, `overflow=0`, `drop_cnt=0`, `deq_val=0`.
- **Timestamps (`TRACE_BUFFER_TSTAMP_EN`):** enqueue on cycles 3 and 7 after reset. Check the dequeued `deq_tstamp` values are 3 and 7.
